// File: rtl/bus_protocol_target_if.sv
// dValid/dAck byte-transfer bus plus the downstream valid/ready FIFO port and status.
// master = bus master / consumer side, slave = the target.
interface bus_protocol_target_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          dValid;
    logic [7:0]    data;
    logic          dAck;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          err_protocol;
    logic          err_overflow;
    logic [LW-1:0] level;

    modport master (
        output dValid, data, out_ready,
        input  dAck, out_valid, out_data, err_protocol, err_overflow, level
    );

    modport slave (
        input  dValid, data, out_ready,
        output dAck, out_valid, out_data, err_protocol, err_overflow, level
    );
endinterface

// File: rtl/bus_protocol_target.sv
// Target end of the dValid/dAck bus: acks each transfer ACK_DELAY edges after it
// starts, queues the byte in a small FIFO and flags master protocol errors / overflow.
module bus_protocol_target #(
    parameter int ACK_DELAY = 1,  // legal 1..3
    parameter int DEPTH     = 4   // power of 2, >= 2
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_protocol_target_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {WAIT_LOW, IDLE, COUNT, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          dack_q, dack_nxt;
    logic          push, perr_set;
    logic          perr_q, ovf_q;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] lvl;
    logic          pop, full, push_ok, ovf_set;

    // cnt holds the index of the edge about to be sampled while in COUNT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dack_nxt  = 1'b0;
        push      = 1'b0;
        perr_set  = 1'b0;
        case (state)
            WAIT_LOW: if (!bus.dValid) state_nxt = IDLE;
            IDLE: begin
                if (bus.dValid) begin
                    state_nxt = COUNT;
                    cnt_nxt   = 2'd1;
                    dack_nxt  = (ACK_DELAY == 1);
                end
            end
            COUNT: begin
                if (!bus.dValid) begin
                    perr_set  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == 2'(ACK_DELAY)) begin
                    push      = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt  = cnt + 2'd1;
                    dack_nxt = (cnt == 2'(ACK_DELAY - 1));
                end
            end
            DRAIN: begin
                perr_set  = bus.dValid;
                state_nxt = bus.dValid ? WAIT_LOW : IDLE;
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    // The master cannot be stalled, so a full FIFO drops the byte but still acks
    assign pop     = (lvl != '0) && bus.out_ready;
    assign full    = (lvl == LW'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WAIT_LOW;
            cnt    <= '0;
            dack_q <= 1'b0;
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            lvl    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dack_q <= dack_nxt;
            if (perr_set) perr_q <= 1'b1;
            if (ovf_set)  ovf_q  <= 1'b1;
            if (push_ok)  wptr   <= wptr + AW'(1);
            if (pop)      rptr   <= rptr + AW'(1);
            lvl <= lvl + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wptr] <= bus.data;
    end

    assign bus.dAck         = dack_q;
    assign bus.out_valid    = (lvl != '0);
    assign bus.out_data     = mem[rptr];
    assign bus.level        = lvl;
    assign bus.err_protocol = perr_q;
    assign bus.err_overflow = ovf_q;
endmodule

// File: tb/tb_bus_protocol_target.sv
// Drives three targets (ACK_DELAY 1,2,3) with shared bus stimulus and checks them
// against a run-length/queue reference model, directed vectors and corner sequences.
module tb_bus_protocol_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] dat = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_protocol_target_if #(.DEPTH(4)) if1 ();
    bus_protocol_target_if #(.DEPTH(4)) if2 ();
    bus_protocol_target_if #(.DEPTH(4)) if3 ();

    assign if1.dValid = dv;  assign if1.data = dat;  assign if1.out_ready = rdy;
    assign if2.dValid = dv;  assign if2.data = dat;  assign if2.out_ready = rdy;
    assign if3.dValid = dv;  assign if3.data = dat;  assign if3.out_ready = rdy;

    bus_protocol_target #(.ACK_DELAY(1), .DEPTH(4)) u1 (.clk(clk), .reset(rst), .bus(if1.slave));
    bus_protocol_target #(.ACK_DELAY(2), .DEPTH(4)) u2 (.clk(clk), .reset(rst), .bus(if2.slave));
    bus_protocol_target #(.ACK_DELAY(3), .DEPTH(4)) u3 (.clk(clk), .reset(rst), .bus(if3.slave));

    logic       aack [3];
    logic       aov  [3];
    logic       aperr[3];
    logic       aovf [3];
    logic [7:0] aod  [3];
    logic [2:0] alvl [3];

    assign aack[0] = if1.dAck;  assign aov[0] = if1.out_valid;  assign aod[0] = if1.out_data;
    assign aack[1] = if2.dAck;  assign aov[1] = if2.out_valid;  assign aod[1] = if2.out_data;
    assign aack[2] = if3.dAck;  assign aov[2] = if3.out_valid;  assign aod[2] = if3.out_data;
    assign alvl[0] = if1.level; assign aperr[0] = if1.err_protocol; assign aovf[0] = if1.err_overflow;
    assign alvl[1] = if2.level; assign aperr[1] = if2.err_protocol; assign aovf[1] = if2.err_overflow;
    assign alvl[2] = if3.level; assign aperr[2] = if3.err_protocol; assign aovf[2] = if3.err_overflow;

    // Reference model: hi = number of consecutive high samples of the current
    // transfer; the high sample with index d is the ack edge. blk = waiting for a low.
    int         hi   [3];
    int         mlen [3];
    bit         blk  [3];
    bit         eack [3];
    bit         eperr[3];
    bit         eovf [3];
    logic [7:0] mq   [3][4];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int d;
            bit push;
            bit pop;
            d    = i + 1;
            push = 1'b0;
            pop  = rdy && (mlen[i] > 0);
            if (rst) begin
                hi[i] = 0; blk[i] = 1'b1; eack[i] = 1'b0;
                eperr[i] = 1'b0; eovf[i] = 1'b0; mlen[i] = 0;
            end else begin
                eack[i] = 1'b0;
                if (blk[i]) begin
                    if (!dv) blk[i] = 1'b0;
                end else if (dv) begin
                    hi[i]++;
                    if (hi[i] - 1 == d - 1) eack[i] = 1'b1;
                    if (hi[i] - 1 == d) push = 1'b1;
                    if (hi[i] - 1 == d + 1) begin
                        eperr[i] = 1'b1; blk[i] = 1'b1; hi[i] = 0;
                    end
                end else begin
                    if (hi[i] >= 1 && hi[i] - 1 < d) eperr[i] = 1'b1;
                    hi[i] = 0;
                end
                if (pop) begin
                    for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
                    mlen[i]--;
                end
                if (push) begin
                    if (mlen[i] < 4) begin
                        mq[i][mlen[i]] = dat;
                        mlen[i]++;
                    end else eovf[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] actv(input int i);
        return {17'd0, aack[i], aov[i], (aov[i] ? aod[i] : 8'h00), alvl[i], aperr[i], aovf[i]};
    endfunction

    // One clock; afterwards compare every target against the model
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ev;
            logic [7:0]  eod;
            eod = (mlen[i] > 0) ? mq[i][0] : 8'h00;
            ev  = {17'd0, eack[i], (mlen[i] > 0), eod, 3'(mlen[i]), eperr[i], eovf[i]};
            chk($sformatf("model_d%0d", i + 1), actv(i), ev);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; dv = 1'b0; rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic xfer(input logic [7:0] b, input int hold, input int di, output int acks);
        acks = 0;
        dv = 1'b1; dat = b;
        repeat (hold) begin
            tick();
            if (aack[di]) acks++;
        end
        dv = 1'b0;
        tick();
        if (aack[di]) acks++;
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] dat;
        logic       rdy;
        logic       ack;
        logic       ov;
        logic [7:0] od;
        logic [2:0] lvl;
        logic       perr;
        logic       ovf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n, total, hold, gap;
        // ACK_DELAY=1 directed vectors: inputs, then outputs after the edge
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};

        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state_d%0d", i + 1), actv(i), 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 14; k++) begin
            dv = tbl[k].dv; dat = tbl[k].dat; rdy = tbl[k].rdy;
            tick();
            chk($sformatf("vec%0d", k), actv(0),
                {17'd0, tbl[k].ack, tbl[k].ov, tbl[k].od, tbl[k].lvl, tbl[k].perr, tbl[k].ovf});
        end

        // ACK_DELAY=3 timing and back-to-back transfers
        do_reset();
        dv = 1'b1; dat = 8'h3C;
        tick(); chk("d3_ack_e0", 32'(aack[2]), 32'd0);
        tick(); chk("d3_ack_e1", 32'(aack[2]), 32'd0);
        tick(); chk("d3_ack_e2", 32'(aack[2]), 32'd1);
        tick(); chk("d3_ack_e3", 32'(aack[2]), 32'd0); chk("d3_lvl1", 32'(alvl[2]), 32'd1);
        dv = 1'b0; tick();
        dv = 1'b1; dat = 8'hC3;
        tick(); tick(); tick(); chk("d3_b2b_ack", 32'(aack[2]), 32'd1);
        tick(); chk("d3_lvl2", 32'(alvl[2]), 32'd2);
        dv = 1'b0; tick();
        chk("d3_head0", 32'(aod[2]), 32'h3C);
        rdy = 1'b1; tick();
        chk("d3_head1", 32'(aod[2]), 32'hC3);
        tick(); chk("d3_empty", 32'(aov[2]), 32'd0);
        rdy = 1'b0;

        // Overflow with ACK_DELAY=2
        do_reset();
        total = 0;
        for (int b = 1; b <= 5; b++) begin
            xfer(8'(b), 3, 1, n);
            total += n;
        end
        chk("ovf_acks", 32'(total), 32'd5);
        chk("ovf_lvl", 32'(alvl[1]), 32'd4);
        chk("ovf_flag", 32'(aovf[1]), 32'd1);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), 32'(aod[1]), 32'(i + 1));
            tick();
        end
        rdy = 1'b0;
        chk("ovf_drained", 32'(aov[1]), 32'd0);

        // Full FIFO with a pop on the ack edge accepts the push
        do_reset();
        for (int b = 1; b <= 4; b++) xfer(8'(b), 3, 1, n);
        chk("full_lvl", 32'(alvl[1]), 32'd4);
        dv = 1'b1; dat = 8'h06;
        tick(); tick();
        rdy = 1'b1; tick();
        rdy = 1'b0; dv = 1'b0; tick();
        chk("fullpop_lvl", 32'(alvl[1]), 32'd4);
        chk("fullpop_ovf", 32'(aovf[1]), 32'd0);
        chk("fullpop_head", 32'(aod[1]), 32'h02);

        // ACK_DELAY=2 protocol violations
        do_reset();
        dv = 1'b1; dat = 8'h77;
        tick(); chk("d2_e0_noack", 32'(aack[1]), 32'd0);
        dv = 1'b0;
        tick();
        chk("d2_early_perr", 32'(aperr[1]), 32'd1);
        chk("d2_early_ack", 32'(aack[1]), 32'd0);
        chk("d2_early_lvl", 32'(alvl[1]), 32'd0);
        do_reset();
        dv = 1'b1; dat = 8'h78;
        tick(); tick(); chk("d2_ack", 32'(aack[1]), 32'd1);
        tick(); tick(); chk("d2_hold_perr", 32'(aperr[1]), 32'd1);
        tick(); chk("d2_hold_noack0", 32'(aack[1]), 32'd0);
        tick(); chk("d2_hold_noack1", 32'(aack[1]), 32'd0);
        dv = 1'b0; tick();
        dv = 1'b1; dat = 8'h88;
        tick(); chk("d2_rearm_e0", 32'(aack[1]), 32'd0);
        tick(); chk("d2_rearm_ack", 32'(aack[1]), 32'd1);
        tick(); dv = 1'b0; tick();

        // dValid high at reset release, then reset in the middle of COUNT
        rst = 1'b1; dv = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstrel_noack%0d", i), 32'(aack[0]), 32'd0);
        end
        dv = 1'b0; tick();
        dv = 1'b1; dat = 8'h05;
        tick(); chk("rstrel_fresh_ack", 32'(aack[0]), 32'd1);
        tick(); tick(); chk("midcount_d3_ack", 32'(aack[2]), 32'd1);
        rst = 1'b1; tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("midcount_rst_d%0d", i + 1), actv(i), 32'd0);
        rst = 1'b0; dv = 1'b0; tick();

        // Randomized transfers with random consumer and occasional resets
        repeat (250) begin
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            hold = int'($urandom_range(1, 5));
            gap  = int'($urandom_range(1, 3));
            dv = 1'b1; dat = 8'($urandom);
            repeat (hold) begin
                rdy = 1'($urandom_range(0, 1));
                tick();
            end
            dv = 1'b0;
            repeat (gap) begin
                rdy = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
